counter_supervisor: RTL and testbench
=====================================

# counter_supervisor

Sequential supervisor placed directly downstream of the saturating threshold counter. It consumes the counter's `counter` value and its `over_run` flag, and drives the counter's reset to restart it after every overrun. Each overrun is reported as a snapshot event on a one-entry valid/ready interface. After a configurable number of overruns the block latches a fault and holds the counter in reset until software acknowledges.

## Interface
- `COUNTER_MSB`, default 7: MSB index of the monitored counter value.
- `EVENT_MSB`, default 3: MSB index of the internal overrun tally and of `event_index`.
- `RESTART_CYCLES`, default 2: number of cycles `counter_rst` is held high per restart; legal range is ≥1.
- `MAX_OVERRUNS`, default 4: tally value that triggers FAULT. 0 disables faulting. Must be ≤ 2^(EVENT_MSB+1)-1.

Ports:
- `clk` input 1: system clock. This is the only clock.
- `rst` input 1: system reset, synchronous, active-high.
- `enable` input 1: run request. While low, the counter is held in reset.
- `counter` input [COUNTER_MSB:0]: count value from the counter.
- `over_run` input 1: overrun flag from the counter.
- `counter_rst` output 1: registered reset to the counter.
- `event_valid` output 1: an event is held.
- `event_ready` input 1: consumer accepts the held event.
- `event_data` output [COUNTER_MSB:0]: `counter` value sampled at the overrun.
- `event_index` output [EVENT_MSB:0]: tally value after this overrun.
- `event_lost` output 1: sticky flag, set when an event was dropped.
- `fault` output 1: fault latched.
- `fault_ack` input 1: clears the fault, the tally and `event_lost`.

## Operation
- Reset values:
  - state IDLE
  - `counter_rst`=1
  - `event_valid`=0, `event_data`=0, `event_index`=0
  - `event_lost`=0, `fault`=0, tally=0
- States:
  - IDLE: `counter_rst`=1. If `enable`=1, go to RUN.
  - RUN: `counter_rst`=0.
    - If `enable`=0, go to IDLE. This takes priority over `over_run`.
    - Else if `over_run`=1, record an overrun event (see below). Go to FAULT if the new tally equals `MAX_OVERRUNS` and `MAX_OVERRUNS`≠0; otherwise go to RESTART.
  - RESTART: `counter_rst`=1 for exactly `RESTART_CYCLES` cycles. Then go to RUN if `enable`=1, else go to IDLE. `enable` is ignored until the restart completes.
  - FAULT: `counter_rst`=1 and `fault`=1. On `fault_ack`=1, go to IDLE, clear tally=0, `event_lost`=0 and `fault`=0. `enable` is ignored in this state.
- `over_run` is sampled only in RUN and is ignored in all other states.
- Tally: increments by 1 per overrun. It saturates at all-ones and never wraps. It is cleared only by `rst` or `fault_ack`.
- Recording an overrun event:
  - Holding register empty, or `event_ready`=1 in the same cycle: load `event_data`=`counter`, `event_index`=new tally, and set `event_valid`=1.
  - Holding register full and `event_ready`=0: keep the held event, drop the new one and set `event_lost`=1. The tally still increments.
- Handshake:
  - An event transfers on any cycle where `event_valid`=1 and `event_ready`=1.
  - After a transfer with no new load, `event_valid`=0 on the next cycle.
  - `event_data` and `event_index` are stable while `event_valid`=1 and the event has not transferred.
- `fault_ack` has no effect outside FAULT, except that it always clears `event_lost`.
- `rst` asserted mid-operation returns every register to its reset value on the next edge. This includes dropping any held event.

## Timing
- Overrun sampled in RUN at edge t. At t+1:
  - state is RESTART (or FAULT)
  - `counter_rst`=1
  - `event_valid`=1, with `event_data` equal to the value `counter` held at t
- RESTART spans t+1 … t+RESTART_CYCLES. At t+RESTART_CYCLES+1 the block is in RUN with `counter_rst`=0.
- IDLE to RUN: `enable` high at edge t gives `counter_rst`=0 at t+1.
- `fault_ack` at edge t in FAULT: `fault`=0 at t+1, in IDLE. With `enable`=1, the block is in RUN at t+2.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
Bench parameters: `COUNTER_MSB`=3, `RESTART_CYCLES`=2, `MAX_OVERRUNS`=3, `EVENT_MSB`=3. The counter model uses threshold 9.

- Reset then `enable`=1, `event_ready`=1:
  - `counter_rst` falls one cycle after `enable`.
  - The first overrun gives `event_data`=9 and `event_index`=1.
  - `counter_rst` is high for exactly 2 cycles.
- Three overruns, each with `event_ready`=1:
  - `event_index` reads 1, 2, 3.
  - `fault`=1 after the third overrun, with `counter_rst` held high.
  - `fault_ack` pulse gives `fault`=0 and tally=0. The next overrun reports `event_index`=1.
- `event_ready`=0 across two overruns:
  - The first event (index 1) is held, the second is dropped, and `event_lost`=1.
  - Raising `event_ready` transfers index 1, then `event_valid`=0.
  - `fault_ack` clears `event_lost`.
- `over_run`=1 in the same cycle `enable` falls in RUN: block goes to IDLE, no event, tally unchanged.
- `enable` dropped during RESTART: both restart cycles complete, then IDLE with `counter_rst` remaining 1.
- `rst` pulsed while in FAULT with an event held: all outputs return to reset values; `event_valid`=0 and `fault`=0 next cycle.

Source files
------------

// File: rtl/counter_supervisor.sv
// Supervisor for a saturating threshold counter: restarts it after each overrun,
// reports overruns as one-entry valid/ready events and latches a fault after repeated overruns.
module counter_supervisor #(
  parameter int unsigned COUNTER_MSB    = 7,
  parameter int unsigned EVENT_MSB      = 3,
  parameter int unsigned RESTART_CYCLES = 2,
  parameter int unsigned MAX_OVERRUNS   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [COUNTER_MSB:0]   counter,
  input  logic                   over_run,
  output logic                   counter_rst,
  output logic                   event_valid,
  input  logic                   event_ready,
  output logic [COUNTER_MSB:0]   event_data,
  output logic [EVENT_MSB:0]     event_index,
  output logic                   event_lost,
  output logic                   fault,
  input  logic                   fault_ack
);

  localparam int unsigned RcW = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
  localparam logic [RcW-1:0] RcLast = RcW'(RESTART_CYCLES - 1);
  localparam logic [RcW-1:0] RcOne = RcW'(1);
  localparam logic [EVENT_MSB:0] TallyOne = (EVENT_MSB + 1)'(1);
  localparam logic [EVENT_MSB:0] TallyMax = '1;
  localparam logic [EVENT_MSB:0] FaultTally = (EVENT_MSB + 1)'(MAX_OVERRUNS);
  localparam bit FaultEn = (MAX_OVERRUNS != 0);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StRestart,
    StFault
  } state_e;

  state_e               state_q, state_d;
  logic [RcW-1:0]       rc_q, rc_d;
  logic [EVENT_MSB:0]   tally_q, tally_d;
  logic                 valid_q, valid_d;
  logic [COUNTER_MSB:0] data_q, data_d;
  logic [EVENT_MSB:0]   index_q, index_d;
  logic                 lost_q, lost_d;
  logic                 counter_rst_q, counter_rst_d;
  logic                 fault_q, fault_d;

  logic                 record;
  logic [EVENT_MSB:0]   tally_inc;

  // Tally saturates at all-ones rather than wrapping.
  assign tally_inc = (tally_q == TallyMax) ? tally_q : tally_q + TallyOne;

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    tally_d = tally_q;
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    lost_d  = lost_q;
    record  = 1'b0;

    if (valid_q && event_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (over_run) begin
          record  = 1'b1;
          tally_d = tally_inc;
          rc_d    = '0;
          if (FaultEn && (tally_inc == FaultTally)) begin
            state_d = StFault;
          end else begin
            state_d = StRestart;
          end
        end
      end
      StRestart: begin
        if (rc_q == RcLast) begin
          state_d = enable ? StRun : StIdle;
        end else begin
          rc_d = rc_q + RcOne;
        end
      end
      StFault: begin
        if (fault_ack) begin
          state_d = StIdle;
          tally_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A held event that transfers this cycle frees the slot for the new one.
    if (record) begin
      if (!valid_q || event_ready) begin
        valid_d = 1'b1;
        data_d  = counter;
        index_d = tally_inc;
      end else begin
        lost_d = 1'b1;
      end
    end

    if (fault_ack) begin
      lost_d = 1'b0;
    end

    counter_rst_d = (state_d != StRun);
    fault_d       = (state_d == StFault);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      rc_q          <= '0;
      tally_q       <= '0;
      valid_q       <= 1'b0;
      data_q        <= '0;
      index_q       <= '0;
      lost_q        <= 1'b0;
      counter_rst_q <= 1'b1;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rc_q          <= rc_d;
      tally_q       <= tally_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
      index_q       <= index_d;
      lost_q        <= lost_d;
      counter_rst_q <= counter_rst_d;
      fault_q       <= fault_d;
    end
  end

  assign counter_rst = counter_rst_q;
  assign event_valid = valid_q;
  assign event_data  = data_q;
  assign event_index = index_q;
  assign event_lost  = lost_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_counter_supervisor.sv
// Directed self-checking bench for counter_supervisor; counter value and overrun flag are
// driven directly, with threshold-9 overruns presenting counter=9.
module tb_counter_supervisor;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] counter;
  logic       over_run;
  logic       counter_rst;
  logic       event_valid;
  logic       event_ready;
  logic [3:0] event_data;
  logic [3:0] event_index;
  logic       event_lost;
  logic       fault;
  logic       fault_ack;

  int checks = 0;
  int errors = 0;

  counter_supervisor #(
    .COUNTER_MSB   (3),
    .EVENT_MSB     (3),
    .RESTART_CYCLES(2),
    .MAX_OVERRUNS  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .counter    (counter),
    .over_run   (over_run),
    .counter_rst(counter_rst),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_data (event_data),
    .event_index(event_index),
    .event_lost (event_lost),
    .fault      (fault),
    .fault_ack  (fault_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".counter_rst"}, {7'd0, counter_rst}, 8'd1);
    chk({tag, ".event_valid"}, {7'd0, event_valid}, 8'd0);
    chk({tag, ".event_data"}, {4'd0, event_data}, 8'd0);
    chk({tag, ".event_index"}, {4'd0, event_index}, 8'd0);
    chk({tag, ".event_lost"}, {7'd0, event_lost}, 8'd0);
    chk({tag, ".fault"}, {7'd0, fault}, 8'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Present one overrun in RUN and check the snapshot visible one edge later.
  task automatic overrun(input string tag, input logic [3:0] val, input logic [3:0] exp_data,
                         input logic [3:0] exp_idx, input logic exp_fault);
    counter  = val;
    over_run = 1'b1;
    tick();
    over_run = 1'b0;
    counter  = 4'd0;
    chk({tag, ".counter_rst"}, {7'd0, counter_rst}, 8'd1);
    chk({tag, ".event_valid"}, {7'd0, event_valid}, 8'd1);
    chk({tag, ".event_data"}, {4'd0, event_data}, {4'd0, exp_data});
    chk({tag, ".event_index"}, {4'd0, event_index}, {4'd0, exp_idx});
    chk({tag, ".fault"}, {7'd0, fault}, {7'd0, exp_fault});
  endtask

  initial begin
    rst         = 1'b1;
    enable      = 1'b0;
    counter     = 4'd0;
    over_run    = 1'b0;
    event_ready = 1'b0;
    fault_ack   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Basic run, first overrun, two-cycle restart.
    enable      = 1'b1;
    event_ready = 1'b1;
    tick();
    chk("run.counter_rst_low", {7'd0, counter_rst}, 8'd0);
    overrun("ov1", 4'd9, 4'd9, 4'd1, 1'b0);
    tick();
    chk("ov1.restart2_rst", {7'd0, counter_rst}, 8'd1);
    chk("ov1.transferred", {7'd0, event_valid}, 8'd0);
    tick();
    chk("ov1.back_to_run", {7'd0, counter_rst}, 8'd0);

    // Enable dropped during restart: restart completes, then IDLE.
    overrun("ov_en", 4'd9, 4'd9, 4'd2, 1'b0);
    enable = 1'b0;
    tick();
    chk("endrop.restart2", {7'd0, counter_rst}, 8'd1);
    tick();
    chk("endrop.idle", {7'd0, counter_rst}, 8'd1);
    tick();
    chk("endrop.idle_hold", {7'd0, counter_rst}, 8'd1);
    enable = 1'b1;
    tick();
    chk("endrop.rerun", {7'd0, counter_rst}, 8'd0);

    // Three overruns to fault, acknowledge, tally restarts at 1.
    do_reset();
    chk_reset_outputs("reset2");
    tick();
    chk("f.run", {7'd0, counter_rst}, 8'd0);
    overrun("f1", 4'd9, 4'd9, 4'd1, 1'b0);
    tick();
    tick();
    overrun("f2", 4'd5, 4'd5, 4'd2, 1'b0);
    tick();
    tick();
    overrun("f3", 4'd9, 4'd9, 4'd3, 1'b1);
    tick();
    tick();
    tick();
    chk("f.hold_fault", {7'd0, fault}, 8'd1);
    chk("f.hold_rst", {7'd0, counter_rst}, 8'd1);
    fault_ack = 1'b1;
    tick();
    fault_ack = 1'b0;
    chk("f.ack_fault", {7'd0, fault}, 8'd0);
    chk("f.ack_idle_rst", {7'd0, counter_rst}, 8'd1);
    tick();
    chk("f.ack_run", {7'd0, counter_rst}, 8'd0);
    overrun("f4", 4'd9, 4'd9, 4'd1, 1'b0);
    tick();
    tick();

    // Backpressure: second event dropped, event_lost sticky until fault_ack.
    do_reset();
    event_ready = 1'b0;
    tick();
    overrun("bp1", 4'd9, 4'd9, 4'd1, 1'b0);
    tick();
    tick();
    chk("bp.held_valid", {7'd0, event_valid}, 8'd1);
    overrun("bp2", 4'd7, 4'd9, 4'd1, 1'b0);
    chk("bp.lost", {7'd0, event_lost}, 8'd1);
    tick();
    tick();
    chk("bp.lost_sticky", {7'd0, event_lost}, 8'd1);
    chk("bp.pre_xfer_idx", {4'd0, event_index}, 8'd1);
    event_ready = 1'b1;
    tick();
    chk("bp.xfer_valid", {7'd0, event_valid}, 8'd0);
    fault_ack = 1'b1;
    tick();
    fault_ack = 1'b0;
    chk("bp.ack_lost", {7'd0, event_lost}, 8'd0);
    chk("bp.ack_still_run", {7'd0, counter_rst}, 8'd0);

    // Overrun coincident with enable falling: IDLE, no event, tally stays 2.
    enable   = 1'b0;
    counter  = 4'd9;
    over_run = 1'b1;
    tick();
    over_run = 1'b0;
    counter  = 4'd0;
    chk("enfall.rst", {7'd0, counter_rst}, 8'd1);
    chk("enfall.no_event", {7'd0, event_valid}, 8'd0);
    chk("enfall.no_fault", {7'd0, fault}, 8'd0);
    enable = 1'b1;
    tick();
    chk("enfall.rerun", {7'd0, counter_rst}, 8'd0);

    // Third overrun faults with the event held, then rst clears everything.
    event_ready = 1'b0;
    overrun("rf", 4'd9, 4'd9, 4'd3, 1'b1);
    tick();
    chk("rf.fault_held", {7'd0, fault}, 8'd1);
    chk("rf.event_held", {7'd0, event_valid}, 8'd1);
    do_reset();
    chk_reset_outputs("rst_in_fault");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
